// File: rtl/seg_sched_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan scheduler.
package seg_sched_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NIBBLE_W   = 4;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2
    } state_t;

    typedef logic [1:0] slot_t;

    // Digit 0 lives in the most-significant nibble.
    function automatic logic [NIBBLE_W-1:0] nibble_sel(
        input logic [NUM_DIGITS*NIBBLE_W-1:0] v,
        input slot_t                          s
    );
        logic [NIBBLE_W-1:0] n;
        case (s)
            2'd0:    n = v[15:12];
            2'd1:    n = v[11:8];
            2'd2:    n = v[7:4];
            default: n = v[3:0];
        endcase
        return n;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] slot_onehot(input slot_t s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Per-slot clock counter; strobes the end of the blanking gap and the end of the slot.
module seg_slot_timer #(
    parameter int DWELL = 50000,
    parameter int BLANK = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_gap_done,
    output logic o_slot_done
);

    localparam int CNT_W = 20;

    logic [CNT_W-1:0] r_cnt;

    assign o_gap_done  = (r_cnt == CNT_W'(BLANK - 1));
    assign o_slot_done = (r_cnt == CNT_W'(DWELL - 1));

    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            r_cnt <= '0;
        end else if (o_slot_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_sched.sv
// 4-digit scan scheduler with blanking gaps and frame-synchronous value loading.
// Optional macro SEG_LEADING_ZERO_BLANK_EN keeps leading-zero digits dark.
module seg_scan_sched
    import seg_sched_pkg::*;
#(
    parameter int DWELL = 50000,
    parameter int BLANK = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  disp_on,
    input  logic                  ld_valid,
    input  logic [15:0]           ld_data,
    output logic                  ld_ready,
    output logic [NIBBLE_W-1:0]   nibble,
    output logic [NUM_DIGITS-1:0] en,
    output logic                  frame_start
);

    state_t              r_state, w_state_nxt;
    slot_t               r_slot, w_slot_nxt;
    logic [15:0]         r_active, w_active_nxt;
    logic [15:0]         r_pending, w_pending_nxt;
    logic                r_full, w_full_nxt;
    logic [NIBBLE_W-1:0] r_nibble;
    logic                r_fs;
    logic                w_gap_done, w_slot_done, w_clr;
    logic                w_fs_nxt, w_xfer, w_hs, w_lit;

    assign w_clr = (r_state == OFF) || !disp_on;

    seg_slot_timer #(
        .DWELL (DWELL),
        .BLANK (BLANK)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_clr),
        .o_gap_done  (w_gap_done),
        .o_slot_done (w_slot_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        if (!disp_on) begin
            w_state_nxt = OFF;
            w_slot_nxt  = 2'd0;
        end else begin
            case (r_state)
                OFF: begin
                    w_state_nxt = GAP;
                    w_slot_nxt  = 2'd0;
                end
                GAP: begin
                    if (w_gap_done) w_state_nxt = SHOW;
                end
                SHOW: begin
                    if (w_slot_done) begin
                        w_state_nxt = GAP;
                        w_slot_nxt  = r_slot + 2'd1;
                    end
                end
                default: begin
                    w_state_nxt = OFF;
                    w_slot_nxt  = 2'd0;
                end
            endcase
        end
    end

    // Pending-to-active transfer lands on the edge entering the frame-start clock,
    // so every slot of a frame sees the same active value.
    assign w_fs_nxt = (w_state_nxt == GAP) && (w_slot_nxt == 2'd0) &&
                      ((r_state == OFF) || ((r_state == SHOW) && w_slot_done));
    assign w_xfer   = (r_state == OFF) || w_fs_nxt;
    assign w_hs     = ld_valid && !r_full;

    always_comb begin
        w_active_nxt  = r_active;
        w_pending_nxt = r_pending;
        w_full_nxt    = r_full;
        if (w_xfer && w_hs) begin
            w_active_nxt = ld_data;
        end else if (w_xfer && r_full) begin
            w_active_nxt = r_pending;
            w_full_nxt   = 1'b0;
        end else if (w_hs) begin
            w_pending_nxt = ld_data;
            w_full_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= OFF;
            r_slot   <= 2'd0;
            r_active <= 16'h0000;
            r_full   <= 1'b0;
            r_nibble <= '0;
            r_fs     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_slot   <= w_slot_nxt;
            r_active <= w_active_nxt;
            r_full   <= w_full_nxt;
            r_nibble <= nibble_sel(w_active_nxt, w_slot_nxt);
            r_fs     <= w_fs_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_pending <= w_pending_nxt;
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        case (r_slot)
            2'd0:    w_lit = (r_active[15:12] != 4'h0);
            2'd1:    w_lit = (r_active[15:8]  != 8'h00);
            2'd2:    w_lit = (r_active[15:4]  != 12'h000);
            default: w_lit = 1'b1;
        endcase
    end
`else
    assign w_lit = 1'b1;
`endif

    assign en          = ((r_state == SHOW) && w_lit) ? slot_onehot(r_slot) : '0;
    assign nibble      = r_nibble;
    assign frame_start = r_fs;
    assign ld_ready    = !r_full;

endmodule

// File: tb/tb_seg_scan_sched.sv
// Directed self-checking bench for seg_scan_sched with DWELL=8, BLANK=2.
module tb_seg_scan_sched;

    localparam int DW = 8;
    localparam int BL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_on;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic [3:0]  nibble;
    logic [3:0]  en;
    logic        frame_start;

    int n_total = 0;
    int n_pass  = 0;

    seg_scan_sched #(
        .DWELL (DW),
        .BLANK (BL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .disp_on     (disp_on),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .nibble      (nibble),
        .en          (en),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Which slots are expected to light for a displayed value.
    function automatic logic [3:0] lit_mask(input logic [15:0] v);
        logic [3:0] m;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        m[0] = (v[15:12] != 4'h0);
        m[1] = (v[15:8]  != 8'h00);
        m[2] = (v[15:4]  != 12'h000);
        m[3] = 1'b1;
`else
        m = 4'hF;
`endif
        return m;
    endfunction

    // Walks ncyc clocks of a frame starting at its frame_start clock.
    // ld_at: one-clock load offer; hold_at: offer held to the end of the frame.
    task automatic check_frame(input logic [15:0] val, input int ld_at, input logic [15:0] ld_val,
                               input int hold_at, input logic [15:0] hold_val, input int ncyc);
        logic [3:0] lit;
        logic [3:0] exp_en;
        logic [3:0] exp_nib;
        int         slot;
        int         pos;
        lit = lit_mask(val);
        for (int i = 0; i < ncyc; i++) begin
            slot    = i / DW;
            pos     = i % DW;
            exp_en  = (pos >= BL && lit[slot]) ? (4'b0001 << slot) : 4'b0000;
            exp_nib = val[15-4*slot -: 4];
            chk($sformatf("frame_start v=%h c=%0d", val, i), {15'd0, frame_start}, {15'd0, i == 0});
            chk($sformatf("en v=%h c=%0d", val, i), {12'd0, en}, {12'd0, exp_en});
            chk($sformatf("nibble v=%h c=%0d", val, i), {12'd0, nibble}, {12'd0, exp_nib});
            chk($sformatf("ld_ready v=%h c=%0d", val, i), {15'd0, ld_ready},
                {15'd0, !(ld_at >= 0 && i > ld_at)});
            if (i == ld_at) begin
                ld_valid = 1'b1;
                ld_data  = ld_val;
            end else if (i == hold_at) begin
                ld_valid = 1'b1;
                ld_data  = hold_val;
            end else if (ld_at >= 0 && i == ld_at + 1) begin
                ld_valid = 1'b0;
            end
            tick();
        end
        if (hold_at < 0) ld_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        disp_on  = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 16'h0000;
        tick();
        tick();
        tick();
        chk("rst en", {12'd0, en}, 16'h0);
        chk("rst nibble", {12'd0, nibble}, 16'h0);
        chk("rst frame_start", {15'd0, frame_start}, 16'h0);
        chk("rst ld_ready", {15'd0, ld_ready}, 16'h1);

        // Enable: frame_start on the first clock after disp_on.
        rst     = 1'b1;
        disp_on = 1'b1;
        tick();
        check_frame(16'h0000, -1, 16'h0, -1, 16'h0, 32);

        // Mid-frame load shows from the next frame only.
        check_frame(16'h0000, 10, 16'h1234, -1, 16'h0, 32);
        check_frame(16'h1234, -1, 16'h0, -1, 16'h0, 32);

        // Back-to-back loads: second stalls until frame_start.
        check_frame(16'h1234, 5, 16'h1111, 8, 16'h2222, 32);
        check_frame(16'h1111, 0, 16'h2222, -1, 16'h0, 32);
        check_frame(16'h2222, -1, 16'h0, -1, 16'h0, 32);

        // Handshake coinciding with the transfer goes straight to active.
        check_frame(16'h2222, 31, 16'h0045, -1, 16'h0, 32);

        // Drop disp_on in SHOW of slot 2.
        check_frame(16'h0045, -1, 16'h0, -1, 16'h0, 18);
        chk("slot2 show en", {12'd0, en}, 16'h0004);
        chk("slot2 show nibble", {12'd0, nibble}, 16'h0004);
        disp_on = 1'b0;
        tick();
        chk("off en", {12'd0, en}, 16'h0);
        chk("off nibble", {12'd0, nibble}, 16'h0);
        chk("off frame_start", {15'd0, frame_start}, 16'h0);
        ld_valid = 1'b1;
        ld_data  = 16'h0000;
        tick();
        ld_valid = 1'b0;
        chk("off load ld_ready", {15'd0, ld_ready}, 16'h1);
        chk("off en 2", {12'd0, en}, 16'h0);
        tick();
        chk("off frame_start 2", {15'd0, frame_start}, 16'h0);
        disp_on = 1'b1;
        tick();
        check_frame(16'h0000, -1, 16'h0, -1, 16'h0, 32);

        // Reset in GAP of slot 3 with pending full.
        check_frame(16'h0000, 3, 16'h9876, -1, 16'h0, 25);
        chk("gap3 en", {12'd0, en}, 16'h0);
        chk("gap3 ld_ready", {15'd0, ld_ready}, 16'h0);
        chk("gap3 nibble", {12'd0, nibble}, 16'h0);
        rst = 1'b0;
        tick();
        chk("mid rst en", {12'd0, en}, 16'h0);
        chk("mid rst ld_ready", {15'd0, ld_ready}, 16'h1);
        chk("mid rst nibble", {12'd0, nibble}, 16'h0);
        chk("mid rst frame_start", {15'd0, frame_start}, 16'h0);
        rst = 1'b1;
        tick();
        check_frame(16'h0000, -1, 16'h0, -1, 16'h0, 32);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
